// File: rtl/cp0_access_pkg.sv
// Shared CP0 defines: register numbers, pipeline op encoding and M/W stage-entry layout.
// The entry layout is sized by the widths below; the cp0_access parameters default to them.
package cp0_access_pkg;

    localparam int CP0_ADDR_W = 5;
    localparam int CP0_SEL_W  = 3;
    localparam int CP0_DATA_W = 32;
    localparam int GPR_W      = 5;

    localparam logic [CP0_ADDR_W-1:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_EPC     = 5'd14;

    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {
        OP_NONE = 2'd0,
        OP_MFC0 = 2'd1,
        OP_MTC0 = 2'd2
    } op_e;

    localparam int OFF_OP    = 0;
    localparam int OFF_ADDR  = OFF_OP + OP_W;
    localparam int OFF_SEL   = OFF_ADDR + CP0_ADDR_W;
    localparam int OFF_WDATA = OFF_SEL + CP0_SEL_W;
    localparam int OFF_RT    = OFF_WDATA + CP0_DATA_W;
    localparam int OFF_RDATA = OFF_RT + GPR_W;
    localparam int ENT_W     = OFF_RDATA + CP0_DATA_W;

    // Both decode bits set is illegal; mtc0 wins so the write side stays deterministic.
    function automatic op_e decode_op(input logic is_mfc0, input logic is_mtc0);
        if (is_mtc0) return OP_MTC0;
        if (is_mfc0) return OP_MFC0;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/cp0_access_stage.sv
// Generic pipeline stage register: valid + data, hold when !load_i, bubble insert, flush kills valid.
// One-cycle latency; flush_i has priority over load and hold.
module cp0_access_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic         bubble_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = vld_i && !bubble_i;
            dat_d = bubble_i ? '0 : dat_i;
        end
        if (flush_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/cp0_access.sv
// CP0 port initiator: mfc0 reads in M, mtc0 writes once from W, result to regfile writeback.
// mfc0 result one cycle after M (two on a port conflict); stall_i holds M/W, stall_req holds EX.
module cp0_access
    import cp0_access_pkg::*;
#(
    parameter int ADDR_W = CP0_ADDR_W,
    parameter int DATA_W = CP0_DATA_W,
    parameter int SEL_W  = CP0_SEL_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid,
    input  logic              ex_is_mfc0,
    input  logic              ex_is_mtc0,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [SEL_W-1:0]  ex_sel,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rt,
    output logic              cp0_en,
    output logic              cp0_wen,
    output logic [ADDR_W-1:0] cp0_addr,
    output logic [DATA_W-1:0] cp0_wdata,
    input  logic [DATA_W-1:0] cp0_rdata,
    output logic              stall_req,
    output logic              wb_we,
    output logic [4:0]        wb_waddr,
    output logic [DATA_W-1:0] wb_wdata
);

    localparam int M_W = OFF_RDATA;

    logic [M_W-1:0]    ex_ent, m_ent;
    logic [ENT_W-1:0]  w_in_ent, w_ent;
    logic              m_valid, w_valid;
    logic              w_done_q, w_done_d;
    logic              wr_fire, rd_fire, m_is_rd, fwd;
    logic [DATA_W-1:0] cap_rdata;

    op_e               m_op, w_op;
    logic [ADDR_W-1:0] m_addr, w_addr;
    logic [SEL_W-1:0]  m_sel, w_sel;
    logic [DATA_W-1:0] w_wdata, w_rdata;
    logic [4:0]        w_rt;

    always_comb begin
        ex_ent = '0;
        ex_ent[OFF_OP +: OP_W]      = decode_op(ex_is_mfc0, ex_is_mtc0);
        ex_ent[OFF_ADDR +: ADDR_W]  = ex_addr;
        ex_ent[OFF_SEL +: SEL_W]    = ex_sel;
        ex_ent[OFF_WDATA +: DATA_W] = ex_wdata;
        ex_ent[OFF_RT +: 5]         = ex_rt;
    end

    cp0_access_stage #(.W(M_W)) u_m_stage (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (!stall_i && !stall_req),
        .flush_i  (flush_i),
        .bubble_i (1'b0),
        .vld_i    (ex_valid && (ex_is_mfc0 || ex_is_mtc0)),
        .dat_i    (ex_ent),
        .vld_o    (m_valid),
        .dat_o    (m_ent)
    );

    // A flushed M entry must not advance, so W takes a bubble in that cycle.
    assign w_in_ent = {cap_rdata, m_ent};

    cp0_access_stage #(.W(ENT_W)) u_w_stage (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (!stall_i),
        .flush_i  (1'b0),
        .bubble_i (stall_req || flush_i),
        .vld_i    (m_valid),
        .dat_i    (w_in_ent),
        .vld_o    (w_valid),
        .dat_o    (w_ent)
    );

    assign m_op    = op_e'(m_ent[OFF_OP +: OP_W]);
    assign m_addr  = m_ent[OFF_ADDR +: ADDR_W];
    assign m_sel   = m_ent[OFF_SEL +: SEL_W];
    assign w_op    = op_e'(w_ent[OFF_OP +: OP_W]);
    assign w_addr  = w_ent[OFF_ADDR +: ADDR_W];
    assign w_sel   = w_ent[OFF_SEL +: SEL_W];
    assign w_wdata = w_ent[OFF_WDATA +: DATA_W];
    assign w_rt    = w_ent[OFF_RT +: 5];
    assign w_rdata = w_ent[OFF_RDATA +: DATA_W];

    // Port accesses are gated by resetn so a pending write dies in the reset cycle itself.
    always_comb begin
        wr_fire   = resetn && w_valid && (w_op == OP_MTC0) && !w_done_q && (w_sel == '0);
        m_is_rd   = m_valid && (m_op == OP_MFC0);
        fwd       = m_is_rd && wr_fire && (m_addr == w_addr) && (m_sel == '0);
        stall_req = m_is_rd && wr_fire && !fwd;
        rd_fire   = resetn && m_is_rd && !wr_fire && (m_sel == '0);
        cap_rdata = '0;
        if (fwd) begin
            cap_rdata = w_wdata;
        end else if (rd_fire) begin
            cap_rdata = cp0_rdata;
        end
        cp0_en    = wr_fire || rd_fire;
        cp0_wen   = wr_fire;
        cp0_addr  = '0;
        cp0_wdata = '0;
        if (wr_fire) begin
            cp0_addr  = w_addr;
            cp0_wdata = w_wdata;
        end else if (rd_fire) begin
            cp0_addr = m_addr;
        end
        w_done_d = stall_i ? (w_done_q || wr_fire) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_done_q <= 1'b0;
        end else begin
            w_done_q <= w_done_d;
        end
    end

    assign wb_we    = w_valid && (w_op == OP_MFC0) && (w_rt != '0);
    assign wb_waddr = w_rt;
    assign wb_wdata = w_rdata;

endmodule

// File: tb/tb_cp0_access.sv
// Bench for cp0_access: directed per-cycle vector table, reset sequence, then random
// traffic checked against an in-order instruction model with a simple CP0 responder.
module tb_cp0_access;

    logic        clk = 1'b0;
    logic        resetn, stall_i, flush_i;
    logic        ex_valid, ex_is_mfc0, ex_is_mtc0;
    logic [4:0]  ex_addr;
    logic [2:0]  ex_sel;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rt;
    logic        cp0_en, cp0_wen, stall_req, wb_we;
    logic [4:0]  cp0_addr, wb_waddr;
    logic [31:0] cp0_wdata, cp0_rdata, wb_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_access dut (
        .clk(clk), .resetn(resetn), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid(ex_valid), .ex_is_mfc0(ex_is_mfc0), .ex_is_mtc0(ex_is_mtc0),
        .ex_addr(ex_addr), .ex_sel(ex_sel), .ex_wdata(ex_wdata), .ex_rt(ex_rt),
        .cp0_en(cp0_en), .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .stall_req(stall_req),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    // CP0 responder: combinational read, write at the clock edge.
    logic [31:0] regs [32];
    logic        rsp_init;
    always_comb cp0_rdata = cp0_en ? regs[cp0_addr] : 32'h0;
    always @(posedge clk) begin
        if (rsp_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            regs[9]  <= 32'h20;
            regs[12] <= 32'h1234;
        end else if (cp0_en && cp0_wen) begin
            regs[cp0_addr] <= cp0_wdata;
        end
    end

    typedef struct {
        logic s, f, v, mf, mt;
        logic [4:0] a; logic [2:0] sl; logic [31:0] wd; logic [4:0] rt;
        logic en, wen; logic [4:0] ca; logic [31:0] cw;
        logic sr, we; logic [4:0] wa; logic [31:0] wv;
    } vec_t;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } ev_t;

    function automatic vec_t mk(input logic s, f, v, mf, mt, input logic [4:0] a,
                                input logic [2:0] sl, input logic [31:0] wd, input logic [4:0] rt,
                                input logic en, wen, input logic [4:0] ca, input logic [31:0] cw,
                                input logic sr, we, input logic [4:0] wa, input logic [31:0] wv);
        vec_t t;
        t.s = s; t.f = f; t.v = v; t.mf = mf; t.mt = mt; t.a = a; t.sl = sl; t.wd = wd; t.rt = rt;
        t.en = en; t.wen = wen; t.ca = ca; t.cw = cw; t.sr = sr; t.we = we; t.wa = wa; t.wv = wv;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, f, v, mf, mt, input logic [4:0] a, input logic [2:0] sl,
                         input logic [31:0] wd, input logic [4:0] rt);
        stall_i = s; flush_i = f; ex_valid = v; ex_is_mfc0 = mf; ex_is_mtc0 = mt;
        ex_addr = a; ex_sel = sl; ex_wdata = wd; ex_rt = rt;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"},    32'(cp0_en), 0);
        chk({nm, "_wen"},   32'(cp0_wen), 0);
        chk({nm, "_addr"},  32'(cp0_addr), 0);
        chk({nm, "_wdata"}, cp0_wdata, 0);
        chk({nm, "_sreq"},  32'(stall_req), 0);
        chk({nm, "_we"},    32'(wb_we), 0);
        chk({nm, "_waddr"}, 32'(wb_waddr), 0);
        chk({nm, "_wbdat"}, wb_wdata, 0);
    endtask

    vec_t        tv[$];
    logic [31:0] arch [32];
    ev_t         exp_wr[$], obs_wr[$], exp_wb[$], obs_wb[$];
    logic        pm_v, pm_mt;
    logic [4:0]  pm_addr, pm_rt;
    logic [2:0]  pm_sel;
    logic [31:0] pm_wd;

    // In-order architectural retirement of the instruction leaving M.
    task automatic commit();
        if (pm_mt) begin
            if (pm_sel == 3'd0) begin
                arch[pm_addr] = pm_wd;
                exp_wr.push_back({pm_addr, pm_wd});
            end
        end else if (pm_rt != 5'd0) begin
            exp_wb.push_back({pm_rt, (pm_sel == 3'd0) ? arch[pm_addr] : 32'h0});
        end
    endtask

    task automatic observe_and_model();
        if (cp0_wen) obs_wr.push_back({cp0_addr, cp0_wdata});
        if (wb_we && !stall_i) obs_wb.push_back({wb_waddr, wb_wdata});
        if (flush_i) begin
            pm_v = 1'b0;
        end else if (!stall_i && !stall_req) begin
            if (pm_v) commit();
            pm_v = ex_valid && (ex_is_mfc0 || ex_is_mtc0);
            pm_mt = ex_is_mtc0; pm_addr = ex_addr; pm_sel = ex_sel; pm_wd = ex_wdata; pm_rt = ex_rt;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             s f v mf mt addr sel wdata    rt  en wen ca  cwdata   sr we wa wbdata
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 9, 0, 0,       8,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,0, 9,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 8, 32'h20));
        tv.push_back(mk(0,0,1,0,1, 9, 0, 100,     0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 9, 0, 0,       3,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,1, 9,  100,     0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 3, 100));
        tv.push_back(mk(0,0,1,0,1, 12,0, 32'h55,  0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 9, 0, 0,       4,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,1, 12, 32'h55,  1,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,0, 9,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 4, 100));
        tv.push_back(mk(0,0,1,0,1, 9, 0, 5,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(1,0,0,0,0, 0, 0, 0,       0,   1,1, 9,  5,       0,0, 0, 0));
        tv.push_back(mk(1,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(1,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,0,1, 9, 0, 32'h77,  0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,1,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,0,1, 9, 1, 32'h88,  0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 9, 2, 0,       6,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 6, 0));
        tv.push_back(mk(0,0,1,1,0, 9, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,0, 9,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 12,0, 0,       7,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 9, 0, 0,       9,   1,0, 12, 0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,0, 9,  0,       0,1, 7, 32'h55));
        tv.push_back(mk(0,0,1,1,0, 9, 0, 0,       11,  0,0, 0,  0,       0,1, 9, 5));
        tv.push_back(mk(1,1,0,0,0, 0, 0, 0,       0,   1,0, 9,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,1, 13,0, 32'h99,  0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));
        tv.push_back(mk(0,0,1,1,0, 13,0, 0,       2,   1,1, 13, 32'h99,  0,0, 0, 0));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   1,0, 13, 0,       0,0, 0, 0));
        tv.push_back(mk(1,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 2, 32'h99));
        tv.push_back(mk(1,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 2, 32'h99));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,1, 2, 32'h99));
        tv.push_back(mk(0,0,0,0,0, 0, 0, 0,       0,   0,0, 0,  0,       0,0, 0, 0));

        resetn = 1'b0; rsp_init = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1; rsp_init = 1'b0;

        foreach (tv[i]) begin
            @(posedge clk); #1;
            drive(tv[i].s, tv[i].f, tv[i].v, tv[i].mf, tv[i].mt, tv[i].a, tv[i].sl, tv[i].wd, tv[i].rt);
            @(negedge clk);
            chk($sformatf("v%0d_en", i),    32'(cp0_en),    32'(tv[i].en));
            chk($sformatf("v%0d_wen", i),   32'(cp0_wen),   32'(tv[i].wen));
            chk($sformatf("v%0d_addr", i),  32'(cp0_addr),  32'(tv[i].ca));
            chk($sformatf("v%0d_wdata", i), cp0_wdata,      tv[i].cw);
            chk($sformatf("v%0d_sreq", i),  32'(stall_req), 32'(tv[i].sr));
            chk($sformatf("v%0d_we", i),    32'(wb_we),     32'(tv[i].we));
            if (tv[i].we) begin
                chk($sformatf("v%0d_waddr", i), 32'(wb_waddr), 32'(tv[i].wa));
                chk($sformatf("v%0d_wbdat", i), wb_wdata,      tv[i].wv);
            end
        end

        // Reset while an mtc0 of COUNT sits in W: the write must be dropped.
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 1, 9, 0, 32'hABC, 0);
        @(negedge clk);
        idle_cycle();
        @(posedge clk); #1;
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_cycle_wen", 32'(cp0_wen), 0);
        chk("rst_cycle_en",  32'(cp0_en), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk_all_zero("post_rst");
        chk("post_rst_count", regs[9], 32'd5);
        @(posedge clk); #1;
        drive(0, 0, 1, 1, 0, 9, 0, 0, 10);
        @(negedge clk);
        idle_cycle();
        chk("post_rst_rd_en",   32'(cp0_en), 1);
        chk("post_rst_rd_addr", 32'(cp0_addr), 9);
        idle_cycle();
        chk("post_rst_we",    32'(wb_we), 1);
        chk("post_rst_waddr", 32'(wb_waddr), 10);
        chk("post_rst_wbdat", wb_wdata, 32'd5);
        idle_cycle();
        idle_cycle();

        // Random traffic against the in-order model.
        for (int i = 0; i < 32; i++) arch[i] = regs[i];
        pm_v = 1'b0; pm_mt = 1'b0; pm_addr = '0; pm_sel = '0; pm_wd = '0; pm_rt = '0;
        for (int c = 0; c < 400; c++) begin
            int r;
            @(posedge clk); #1;
            r = $urandom_range(0, 9);
            ex_valid   = ($urandom_range(0, 9) < 7);
            ex_is_mfc0 = (r < 4) || (r == 8);
            ex_is_mtc0 = (r >= 4) && (r <= 8);
            case ($urandom_range(0, 2))
                0:       ex_addr = 5'd9;
                1:       ex_addr = 5'd12;
                default: ex_addr = 5'd13;
            endcase
            ex_sel   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            ex_rt    = 5'($urandom_range(0, 31));
            ex_wdata = $urandom;
            stall_i  = ($urandom_range(0, 4) == 0);
            flush_i  = ($urandom_range(0, 19) == 0);
            if (c >= 390) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            observe_and_model();
        end

        chk("rnd_wr_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
        chk("rnd_wb_count", 32'(obs_wb.size()), 32'(exp_wb.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            chk($sformatf("rnd_wr%0d_addr", i), 32'(obs_wr[i].a), 32'(exp_wr[i].a));
            chk($sformatf("rnd_wr%0d_data", i), obs_wr[i].d, exp_wr[i].d);
        end
        for (int i = 0; i < exp_wb.size() && i < obs_wb.size(); i++) begin
            chk($sformatf("rnd_wb%0d_addr", i), 32'(obs_wb[i].a), 32'(exp_wb[i].a));
            chk($sformatf("rnd_wb%0d_data", i), obs_wb[i].d, exp_wb[i].d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
